// File: rtl/pht_update_queue_if.sv
// Bundle between branch resolution, the PHT write port and the update queue.
// The master side drives branch results and fetch busy; the slave side is the queue.
interface pht_update_queue_if #(
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int GHR_WIDTH       = 10,
  parameter int PC_WIDTH        = 32,
  parameter int CNT_WIDTH       = 6
);
  // Handshake: brValid is a one-cycle offer with no ready; a conditional branch
  // offered while the queue is full and not draining is dropped and flagged by
  // overflow in that same cycle. phtWE is a fire-and-forget write strobe.
  logic                       brValid;
  logic [PC_WIDTH-1:0]        brAddr;
  logic                       brExecTaken;
  logic                       brIsCondBr;
  logic [GHR_WIDTH-1:0]       brGlobalHistory;
  logic [1:0]                 brPhtPrevValue;
  logic                       phtReadBusy;
  logic                       phtWE;
  logic [PHT_INDEX_WIDTH-1:0] phtWA;
  logic [1:0]                 phtWV;
  logic [CNT_WIDTH-1:0]       count;
  logic                       full;
  logic                       overflow;

  modport master (
    output brValid, brAddr, brExecTaken, brIsCondBr, brGlobalHistory,
           brPhtPrevValue, phtReadBusy,
    input  phtWE, phtWA, phtWV, count, full, overflow
  );

  modport slave (
    input  brValid, brAddr, brExecTaken, brIsCondBr, brGlobalHistory,
           brPhtPrevValue, phtReadBusy,
    output phtWE, phtWA, phtWV, count, full, overflow
  );
endinterface

// File: rtl/pht_update_queue.sv
// FIFO of gshare PHT counter updates; the index and next counter value are
// computed on enqueue, and entries drain whenever fetch leaves the PHT port idle.
module pht_update_queue #(
  parameter int QUEUE_DEPTH     = 32,
  parameter int PHT_INDEX_WIDTH = 10,
  parameter int GHR_WIDTH       = 10,
  parameter int PC_WIDTH        = 32
) (
  input logic              clk,
  input logic              rst,
  pht_update_queue_if.slave bus
);
  localparam int PTR_W   = $clog2(QUEUE_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = PHT_INDEX_WIDTH + 2;

  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] mem_q [QUEUE_DEPTH];

  logic [PHT_INDEX_WIDTH-1:0] hist;
  logic [PHT_INDEX_WIDTH-1:0] idx;
  logic [1:0]                 next_val;
  logic                       full;
  logic                       deq;
  logic                       enq;
  logic                       cond_offer;

  // History folded onto the index width: zero-extend if short, truncate if long.
  if (GHR_WIDTH < PHT_INDEX_WIDTH) begin : g_hist_ext
    assign hist = {{(PHT_INDEX_WIDTH-GHR_WIDTH){1'b0}}, bus.brGlobalHistory};
  end else begin : g_hist_trunc
    assign hist = bus.brGlobalHistory[PHT_INDEX_WIDTH-1:0];
  end

  always_comb begin
    idx = bus.brAddr[PHT_INDEX_WIDTH+1:2] ^ hist;
    next_val = bus.brPhtPrevValue;
    if (bus.brExecTaken) begin
      if (bus.brPhtPrevValue != 2'd3) next_val = bus.brPhtPrevValue + 2'd1;
    end else begin
      if (bus.brPhtPrevValue != 2'd0) next_val = bus.brPhtPrevValue - 2'd1;
    end
  end

  // Draining is suppressed in the reset cycle so no stale entry reaches the PHT.
  always_comb begin
    full       = (count_q == CNT_W'(QUEUE_DEPTH));
    cond_offer = bus.brValid & bus.brIsCondBr;
    deq        = (count_q != '0) & ~bus.phtReadBusy & ~rst;
    enq        = cond_offer & (~full | deq);
  end

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (deq) head_d = head_q + PTR_W'(1);
    if (enq) tail_d = tail_q + PTR_W'(1);
    if (enq && !deq) count_d = count_q + CNT_W'(1);
    else if (deq && !enq) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Entry storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (enq && !rst) mem_q[tail_q] <= {idx, next_val};
  end

  assign bus.phtWE    = deq;
  assign bus.phtWA    = mem_q[head_q][ENTRY_W-1:2];
  assign bus.phtWV    = mem_q[head_q][1:0];
  assign bus.count    = count_q;
  assign bus.full     = full;
  assign bus.overflow = cond_offer & full & ~deq & ~rst;
endmodule

// File: tb/tb_pht_update_queue.sv
// Directed bench for pht_update_queue: single-shot updates, hashing and
// saturation, full/overflow, drain ordering, non-conditional filtering, reset.
module tb_pht_update_queue;
  logic clk;
  logic rst;
  int   n_vec;
  int   n_bad;
  logic [11:0] exp_q[$];
  logic [1:0]  inc_tab [4];

  pht_update_queue_if #(.PHT_INDEX_WIDTH(10), .GHR_WIDTH(10), .PC_WIDTH(32), .CNT_WIDTH(6)) bus ();

  pht_update_queue #(
    .QUEUE_DEPTH(32), .PHT_INDEX_WIDTH(10), .GHR_WIDTH(10), .PC_WIDTH(32)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // driver: present one branch result for exactly one edge
  task automatic set_br(input logic [31:0] addr, input logic [9:0] ghr,
                        input logic [1:0] prev, input logic taken, input logic cond);
    bus.brValid         = 1'b1;
    bus.brAddr          = addr;
    bus.brGlobalHistory = ghr;
    bus.brPhtPrevValue  = prev;
    bus.brExecTaken     = taken;
    bus.brIsCondBr      = cond;
  endtask

  task automatic clr_br();
    bus.brValid    = 1'b0;
    bus.brIsCondBr = 1'b0;
  endtask

  task automatic send(input logic [31:0] addr, input logic [9:0] ghr,
                      input logic [1:0] prev, input logic taken);
    set_br(addr, ghr, prev, taken, 1'b1);
    tick();
    clr_br();
    #2;
  endtask

  task automatic drain_all(input string tag);
    logic [11:0] e;
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_we"}, 32'(bus.phtWE), 32'd1);
      check({tag, "_wa"}, 32'(bus.phtWA), 32'(e[11:2]));
      check({tag, "_wv"}, 32'(bus.phtWV), 32'(e[1:0]));
      tick();
      #2;
    end
    check({tag, "_cnt_end"}, 32'(bus.count), 32'd0);
    check({tag, "_we_end"}, 32'(bus.phtWE), 32'd0);
  endtask

  initial begin
    n_vec = 0;
    n_bad = 0;
    inc_tab[0] = 2'd1; inc_tab[1] = 2'd2; inc_tab[2] = 2'd3; inc_tab[3] = 2'd3;
    rst = 1'b1;
    bus.phtReadBusy = 1'b0;
    bus.brAddr = '0; bus.brGlobalHistory = '0; bus.brPhtPrevValue = '0;
    bus.brExecTaken = 1'b0;
    clr_br();
    tick(); tick();
    rst = 1'b0;
    #2;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_we", 32'(bus.phtWE), 32'd0);
    check("rst_full", 32'(bus.full), 32'd0);
    check("rst_ovf", 32'(bus.overflow), 32'd0);

    // single update: 0x1004 -> idx 0x001, 1 taken -> 2
    set_br(32'h0000_1004, 10'h000, 2'd1, 1'b1, 1'b1);
    #2;
    check("t1_no_bypass", 32'(bus.phtWE), 32'd0);
    tick(); clr_br(); #2;
    check("t1_we", 32'(bus.phtWE), 32'd1);
    check("t1_wa", 32'(bus.phtWA), 32'h001);
    check("t1_wv", 32'(bus.phtWV), 32'd2);
    check("t1_cnt1", 32'(bus.count), 32'd1);
    tick(); #2;
    check("t1_cnt0", 32'(bus.count), 32'd0);
    check("t1_we0", 32'(bus.phtWE), 32'd0);

    // saturation and hash
    send(32'h0000_0010, 10'h000, 2'd3, 1'b1);
    check("t2_sat_hi_wa", 32'(bus.phtWA), 32'h004);
    check("t2_sat_hi_wv", 32'(bus.phtWV), 32'd3);
    tick(); #2;
    send(32'h0000_0020, 10'h000, 2'd0, 1'b0);
    check("t2_sat_lo_wa", 32'(bus.phtWA), 32'h008);
    check("t2_sat_lo_wv", 32'(bus.phtWV), 32'd0);
    tick(); #2;
    send(32'h0000_0FFC, 10'h3FF, 2'd2, 1'b1);
    check("t2_hash0_wa", 32'(bus.phtWA), 32'h000);
    check("t2_hash0_wv", 32'(bus.phtWV), 32'd3);
    tick(); #2;
    send(32'h0000_1004, 10'h155, 2'd2, 1'b0);
    check("t2_xor_wa", 32'(bus.phtWA), 32'h154);
    check("t2_xor_wv", 32'(bus.phtWV), 32'd1);
    tick(); #2;
    check("t2_cnt0", 32'(bus.count), 32'd0);

    // fill under busy, overflow, ordered drain
    bus.phtReadBusy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(32'(i * 4), 10'h000, 2'(i % 4), 1'b1);
      exp_q.push_back({10'(i), inc_tab[i % 4]});
    end
    check("t3_cnt32", 32'(bus.count), 32'd32);
    check("t3_full", 32'(bus.full), 32'd1);
    check("t3_we_busy", 32'(bus.phtWE), 32'd0);
    set_br(32'h0000_0300, 10'h000, 2'd1, 1'b1, 1'b1);
    #2;
    check("t3_ovf", 32'(bus.overflow), 32'd1);
    tick(); clr_br(); #2;
    check("t3_ovf_pulse", 32'(bus.overflow), 32'd0);
    check("t3_cnt_hold", 32'(bus.count), 32'd32);
    bus.phtReadBusy = 1'b0;
    #2;
    drain_all("t3");

    // full, not busy, simultaneous enqueue: head written, new update accepted
    bus.phtReadBusy = 1'b1;
    for (int i = 0; i < 32; i++) begin
      send(32'(32'h100 + i * 4), 10'h000, 2'd3, 1'b0);
      exp_q.push_back({10'(12'h040 + i), 2'd2});
    end
    bus.phtReadBusy = 1'b0;
    set_br(32'h0000_0200, 10'h000, 2'd0, 1'b1, 1'b1);
    #2;
    check("t4_ovf", 32'(bus.overflow), 32'd0);
    check("t4_we", 32'(bus.phtWE), 32'd1);
    check("t4_head_wa", 32'(bus.phtWA), 32'h040);
    check("t4_head_wv", 32'(bus.phtWV), 32'd2);
    void'(exp_q.pop_front());
    exp_q.push_back({10'h080, 2'd1});
    tick(); clr_br(); #2;
    check("t4_cnt32", 32'(bus.count), 32'd32);
    drain_all("t4");

    // unconditional branch never enqueues
    set_br(32'h0000_0040, 10'h000, 2'd1, 1'b1, 1'b0);
    #2;
    check("t5_ovf", 32'(bus.overflow), 32'd0);
    tick(); clr_br(); #2;
    check("t5_cnt", 32'(bus.count), 32'd0);
    check("t5_we", 32'(bus.phtWE), 32'd0);

    // reset discards pending work
    bus.phtReadBusy = 1'b1;
    for (int i = 0; i < 5; i++) send(32'(i * 4), 10'h000, 2'd1, 1'b1);
    check("t6_cnt5", 32'(bus.count), 32'd5);
    rst = 1'b1;
    bus.phtReadBusy = 1'b0;
    #2;
    check("t6_we_in_rst", 32'(bus.phtWE), 32'd0);
    tick();
    rst = 1'b0;
    #2;
    check("t6_cnt0", 32'(bus.count), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check("t6_no_write", 32'(bus.phtWE), 32'd0);
      tick(); #2;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
